// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg
// Shared definitions for the sequential shift-add multiplier: the FSM state
// encoding and a helper that sizes the step counter.
// Ports: none (package).
package seq_multiplier_pkg;

  // Operation states: waiting for a start, iterating over multiplier bits,
  // and the single result-valid cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_step.sv
// mult_step
// One shift-add iteration of the multiplier datapath. If the current
// multiplier bit is set, the pre-shifted multiplicand is added to (or, for
// the sign-bit step of a signed multiply, subtracted from) the accumulator.
// All arithmetic wraps modulo 2^WIDTH.
// Ports:
//   acc     - current accumulator value
//   addend  - multiplicand already shifted into position for this step
//   bit_set - multiplier bit being processed
//   sub     - 1 = subtract the addend instead of adding it
//   acc_next- accumulator value after this step
module mult_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] addend,
  input  logic             bit_set,
  input  logic             sub,
  output logic [WIDTH-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    if (bit_set) begin
      acc_next = sub ? (acc - addend) : (acc + addend);
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier
// Multi-cycle shift-add multiplier. One multiplier bit is consumed per clock;
// the product is published on the cycle o_finished pulses and held until the
// next operation completes. Signed mode treats both operands as two's
// complement: the multiplicand is sign-extended and the multiplier's sign bit
// carries negative weight, so the final step subtracts.
// Optional feature: define SEQ_MULTIPLIER_EARLY_TERMINATE_EN to finish as soon
// as every unprocessed multiplier bit is zero (1..WIDTH_B steps).
// Ports:
//   i_clock        - system clock, rising edge
//   i_reset        - synchronous active-high reset
//   i_start        - start request, accepted in IDLE or DONE
//   i_signed       - 1 = two's-complement operands, latched at start
//   i_multiplicand - operand A (WIDTH_A bits), latched at start
//   i_multiplier   - operand B (WIDTH_B bits), latched at start
//   o_busy         - high while in RUN
//   o_finished     - one-cycle pulse, product valid
//   o_product      - WIDTH_A+WIDTH_B bit result
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_signed,
  input  logic [WIDTH_A-1:0]         i_multiplicand,
  input  logic [WIDTH_B-1:0]         i_multiplier,
  output logic                       o_busy,
  output logic                       o_finished,
  output logic [WIDTH_A+WIDTH_B-1:0] o_product
);

  localparam int WIDTH_P = WIDTH_A + WIDTH_B;
  localparam int CW      = cnt_width(WIDTH_B);

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH_P-1:0] acc;
  logic [WIDTH_P-1:0] mcand;
  logic [WIDTH_B-1:0] mplier;
  logic               signed_mode;

  logic [WIDTH_P-1:0] acc_next;
  logic               final_bit;
  logic               last_step;
  logic               sub;

  // The multiplicand register is shifted left each step so it always sits at
  // the weight of the multiplier bit currently in mplier[0].
  mult_step #(
    .WIDTH(WIDTH_P)
  ) u_step (
    .acc      (acc),
    .addend   (mcand),
    .bit_set  (mplier[0]),
    .sub      (sub),
    .acc_next (acc_next)
  );

  assign final_bit = (count == CW'(1));

  // Only the sign bit of a signed multiplier has negative weight.
  assign sub = signed_mode && final_bit;

`ifdef SEQ_MULTIPLIER_EARLY_TERMINATE_EN
  // Once the bits above the one being processed are all zero they cannot
  // contribute anything, so this step already yields the final product.
  assign last_step = final_bit || (mplier[WIDTH_B-1:1] == '0);
`else
  assign last_step = final_bit;
`endif

  // Control FSM plus datapath registers. A start is accepted from IDLE and
  // from DONE alike so back-to-back operations need no idle cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      signed_mode <= 1'b0;
      o_busy      <= 1'b0;
      o_finished  <= 1'b0;
      o_product   <= '0;
    end else begin
      case (state)
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (last_step) begin
            state      <= DONE;
            o_product  <= acc_next;
            o_finished <= 1'b1;
            o_busy     <= 1'b0;
          end
        end
        default: begin
          o_finished <= 1'b0;
          if (i_start) begin
            state       <= RUN;
            o_busy      <= 1'b1;
            count       <= CW'(WIDTH_B);
            acc         <= '0;
            mplier      <= i_multiplier;
            signed_mode <= i_signed;
            mcand       <= i_signed
                         ? {{WIDTH_B{i_multiplicand[WIDTH_A-1]}}, i_multiplicand}
                         : {{WIDTH_B{1'b0}}, i_multiplicand};
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier
// Self-checking bench for seq_multiplier. Two instances are exercised: the
// default 4x4 configuration and a 3x5 configuration. Expected products come
// from plain integer multiplication of the interpreted operand values, and
// expected latency from the position of the highest set multiplier bit.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic reset;

  logic       start0, sgn0;
  logic [3:0] a0, b0;
  logic       busy0, fin0;
  logic [7:0] prod0;

  logic       start1, sgn1;
  logic [2:0] a1;
  logic [4:0] b1;
  logic       busy1, fin1;
  logic [7:0] prod1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH_A(4), .WIDTH_B(4)) dut (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_start        (start0),
    .i_signed       (sgn0),
    .i_multiplicand (a0),
    .i_multiplier   (b0),
    .o_busy         (busy0),
    .o_finished     (fin0),
    .o_product      (prod0)
  );

  seq_multiplier #(.WIDTH_A(3), .WIDTH_B(5)) dut35 (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_start        (start1),
    .i_signed       (sgn1),
    .i_multiplicand (a1),
    .i_multiplier   (b1),
    .o_busy         (busy1),
    .o_finished     (fin1),
    .o_product      (prod1)
  );

  // Reference product: interpret operands as integers, multiply, wrap.
  function automatic longint ref_prod(input int wa, input int wb,
                                      input longint a, input longint b,
                                      input bit s);
    longint av = a;
    longint bv = b;
    if (s && a[wa-1]) av = a - (longint'(1) << wa);
    if (s && b[wb-1]) bv = b - (longint'(1) << wb);
    return (av * bv) & ((longint'(1) << (wa + wb)) - 1);
  endfunction

  // Reference latency in steps between the accepting edge and the result.
  function automatic int ref_lat(input int wb, input longint b);
`ifdef SEQ_MULTIPLIER_EARLY_TERMINATE_EN
    int n = 1;
    for (int i = 0; i < wb; i++) if (b[i]) n = i + 1;
    return n;
`else
    return wb + 0 * int'(b[0]);
`endif
  endfunction

  // Runs one operation on the selected instance and reports product,
  // observed latency (-1 on timeout) and the number of busy cycles.
  task automatic do_op(input bit which, input logic [7:0] av, input logic [7:0] bv,
                       input bit sv, output logic [7:0] p, output int lat,
                       output int bc);
    @(negedge clk);
    if (!which) begin
      start0 = 1'b1; sgn0 = sv; a0 = av[3:0]; b0 = bv[3:0];
    end else begin
      start1 = 1'b1; sgn1 = sv; a1 = av[2:0]; b1 = bv[4:0];
    end
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0;
    a0 = 4'($urandom); b0 = 4'($urandom); sgn0 = 1'($urandom);
    a1 = 3'($urandom); b1 = 5'($urandom); sgn1 = 1'($urandom);
    lat = -1; bc = 0; p = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (which ? busy1 : busy0) bc++;
      if (which ? fin1 : fin0) begin
        lat = c - 1;
        p = which ? prod1 : prod0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (busy0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy0); end
    if (fin0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_finished got=%b exp=0", fin0); end
    if (prod0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_product got=%h exp=00", prod0); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0] ta [7] = '{4'hF, 4'h8, 4'hF, 4'h7, 4'h8, 4'hF, 4'h7};
    logic [3:0] tb [7] = '{4'hF, 4'h8, 4'h7, 4'h8, 4'h8, 4'h7, 4'h8};
    bit         ts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] te [7] = '{8'hE1, 8'h40, 8'hF9, 8'hC8, 8'h40, 8'h69, 8'h38};
    logic [7:0] p;
    int lat, bc;
    for (int i = 0; i < 7; i++) begin
      do_op(1'b0, {4'h0, ta[i]}, {4'h0, tb[i]}, ts[i], p, lat, bc);
      checks += 3;
      if (p !== te[i]) begin
        failures++; $display("[TB] FAIL directed_product case=%0d got=%h exp=%h", i, p, te[i]);
      end
      if (lat != ref_lat(4, longint'(tb[i]))) begin
        failures++; $display("[TB] FAIL directed_latency case=%0d got=%0d exp=%0d", i, lat, ref_lat(4, longint'(tb[i])));
      end
      if (bc != lat) begin
        failures++; $display("[TB] FAIL directed_busy case=%0d got=%0d exp=%0d", i, bc, lat);
      end
    end
  endtask

  task automatic test_sweep(input bit which);
    int wa = which ? 3 : 4;
    int wb = which ? 5 : 4;
    logic [7:0] p, e;
    int lat;
    int bc;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < (1 << wa); a++)
        for (int b = 0; b < (1 << wb); b++) begin
          do_op(which, 8'(a), 8'(b), s[0], p, lat, bc);
          e = 8'(ref_prod(wa, wb, longint'(a), longint'(b), s[0]));
          checks += 2;
          if (p !== e) begin
            failures++;
            $display("[TB] FAIL sweep_product cfg=%0dx%0d s=%0d a=%0d b=%0d got=%h exp=%h", wa, wb, s, a, b, p, e);
          end
          if (lat != ref_lat(wb, longint'(b))) begin
            failures++;
            $display("[TB] FAIL sweep_latency cfg=%0dx%0d a=%0d b=%0d got=%0d exp=%0d", wa, wb, a, b, lat, ref_lat(wb, longint'(b)));
          end
        end
  endtask

  task automatic test_ignore_start();
    logic [3:0] av, bv;
    bit sv;
    logic [7:0] e, p;
    int lat;
    for (int n = 0; n < 6; n++) begin
      av = 4'($urandom); bv = 4'($urandom) | 4'h8; sv = 1'($urandom);
      e = 8'(ref_prod(4, 4, longint'(av), longint'(bv), sv));
      @(negedge clk);
      start0 = 1'b1; a0 = av; b0 = bv; sgn0 = sv;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      lat = -1; p = '0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (fin0) begin lat = c - 1; p = prod0; break; end
        if (c == 2) begin start0 = 1'b1; a0 = ~av; b0 = 4'($urandom); sgn0 = ~sv; end
        if (c == 3) start0 = 1'b0;
      end
      checks += 2;
      if (p !== e) begin failures++; $display("[TB] FAIL ignore_start_product got=%h exp=%h", p, e); end
      if (lat != 4) begin failures++; $display("[TB] FAIL ignore_start_latency got=%0d exp=4", lat); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] p, e;
    int lat, bc;
    bit seen_fin;
    do_op(1'b0, 8'h3, 8'h5, 1'b0, p, lat, bc);
    @(negedge clk);
    start0 = 1'b1; a0 = 4'h6; b0 = 4'hB; sgn0 = 1'b0;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    seen_fin = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (fin0) seen_fin = 1'b1;
      if (c == 2) reset = 1'b1;
      if (c == 3) begin
        checks += 2;
        if (busy0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_busy got=%b exp=0", busy0); end
        if (prod0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_mid_product got=%h exp=00", prod0); end
        reset = 1'b0;
      end
    end
    checks++;
    if (seen_fin) begin failures++; $display("[TB] FAIL reset_mid_no_finish got=1 exp=0"); end
    do_op(1'b0, 8'h9, 8'hD, 1'b1, p, lat, bc);
    e = 8'(ref_prod(4, 4, 64'h9, 64'hD, 1'b1));
    checks += 2;
    if (p !== e) begin failures++; $display("[TB] FAIL reset_recover_product got=%h exp=%h", p, e); end
    if (lat != ref_lat(4, 64'hD)) begin failures++; $display("[TB] FAIL reset_recover_latency got=%0d exp=%0d", lat, ref_lat(4, 64'hD)); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a_1, b_1, a_2, b_2;
    bit s_1, s_2;
    logic [7:0] p1, p2;
    int lat1, lat2;
    for (int n = 0; n < 8; n++) begin
      a_1 = 4'($urandom); b_1 = 4'($urandom); s_1 = 1'($urandom);
      a_2 = 4'($urandom); b_2 = 4'($urandom); s_2 = 1'($urandom);
      @(negedge clk);
      start0 = 1'b1; a0 = a_1; b0 = b_1; sgn0 = s_1;
      @(posedge clk);
      #1;
      a0 = a_2; b0 = b_2; sgn0 = s_2;
      lat1 = -1; p1 = '0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (fin0) begin lat1 = c - 1; p1 = prod0; break; end
      end
      @(posedge clk);
      #1;
      start0 = 1'b0;
      lat2 = -1; p2 = '0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (c == 1) begin
          checks++;
          if (busy0 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_no_idle busy got=%b exp=1", busy0); end
        end
        if (fin0) begin lat2 = c - 1; p2 = prod0; break; end
      end
      checks += 4;
      if (p1 !== 8'(ref_prod(4, 4, longint'(a_1), longint'(b_1), s_1))) begin
        failures++; $display("[TB] FAIL b2b_product1 got=%h exp=%h", p1, 8'(ref_prod(4, 4, longint'(a_1), longint'(b_1), s_1)));
      end
      if (lat1 != ref_lat(4, longint'(b_1))) begin
        failures++; $display("[TB] FAIL b2b_latency1 got=%0d exp=%0d", lat1, ref_lat(4, longint'(b_1)));
      end
      if (p2 !== 8'(ref_prod(4, 4, longint'(a_2), longint'(b_2), s_2))) begin
        failures++; $display("[TB] FAIL b2b_product2 got=%h exp=%h", p2, 8'(ref_prod(4, 4, longint'(a_2), longint'(b_2), s_2)));
      end
      if (lat2 != ref_lat(4, longint'(b_2))) begin
        failures++; $display("[TB] FAIL b2b_latency2 got=%0d exp=%0d", lat2, ref_lat(4, longint'(b_2)));
      end
    end
  endtask

`ifdef SEQ_MULTIPLIER_EARLY_TERMINATE_EN
  task automatic test_early_terminate();
    logic [7:0] p;
    int lat, bc;
    do_op(1'b0, 8'h5, 8'h1, 1'b0, p, lat, bc);
    checks += 2;
    if (p !== 8'h05) begin failures++; $display("[TB] FAIL early_5x1_product got=%h exp=05", p); end
    if (lat != 1) begin failures++; $display("[TB] FAIL early_5x1_latency got=%0d exp=1", lat); end
    do_op(1'b0, 8'h5, 8'h0, 1'b0, p, lat, bc);
    checks += 2;
    if (p !== 8'h00) begin failures++; $display("[TB] FAIL early_5x0_product got=%h exp=00", p); end
    if (lat != 1) begin failures++; $display("[TB] FAIL early_5x0_latency got=%0d exp=1", lat); end
  endtask
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    start0 = 1'b0; sgn0 = 1'b0; a0 = '0; b0 = '0;
    start1 = 1'b0; sgn1 = 1'b0; a1 = '0; b1 = '0;
    test_reset();
    test_directed();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef SEQ_MULTIPLIER_EARLY_TERMINATE_EN
    test_early_terminate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Multi-cycle shift-add multiplier with independent operand widths, per-operation signed/unsigned mode and a start/busy/finished handshake. It processes one multiplier bit per clock and holds the product until the next operation. It is the general-purpose multiply unit for datapaths that cannot afford a combinational array multiplier.

Parameters:
WIDTH_A, 4, multiplicand width in bits (>= 2)
WIDTH_B, 4, multiplier width in bits (>= 2); sets the iteration count
WIDTH_P, WIDTH_A+WIDTH_B, product width (derived; not overridable)

Ports:
i_clock  input  1  system clock; all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_start  input  1  request a new multiply; sampled on rising edge
i_signed  input  1  1 = two's-complement operands, 0 = unsigned; latched with operands
i_multiplicand  input  WIDTH_A  operand A; latched on accepted start
i_multiplier  input  WIDTH_B  operand B; latched on accepted start
o_busy  output  1  high while an operation is in progress (state RUN)
o_finished  output  1  one-cycle pulse; o_product valid in that cycle
o_product  output  WIDTH_P  result; held stable from the o_finished pulse until the next accepted start completes

Behaviour:
- Reset (i_reset=1 at an edge): state=IDLE; o_busy=0; o_finished=0; o_product=0; internal counter, accumulator and operand registers cleared. Reset has priority over everything, including mid-operation abort. No o_finished pulse is emitted for the aborted operation.
- FSM states:
  - IDLE: i_start=1 latches the operands and i_signed, clears the accumulator, loads the counter with WIDTH_B, and goes to RUN.
  - RUN: one step per cycle. The counter decrements each step. The step that brings the counter to 0 moves to DONE, writes o_product, and sets o_finished=1.
  - DONE: o_finished=1 for exactly this cycle. Next edge goes to IDLE; if i_start=1 in DONE, the start is accepted as from IDLE (goes directly to RUN).
- Latency: start accepted at edge k; steps at edges k+1..k+WIDTH_B; o_finished high in the cycle following edge k+WIDTH_B. Back-to-back throughput is one result per WIDTH_B+1 cycles.
- i_start during RUN is ignored: operands are not re-latched and the operation is not restarted.
- Step i (i = 0..WIDTH_B-1): if bit i of the latched multiplier is 1, add (multiplicand << i) to the accumulator. In signed mode the multiplicand is sign-extended to WIDTH_P, and step WIDTH_B-1 subtracts instead of adds. In unsigned mode it is zero-extended.
- Arithmetic is modulo 2^WIDTH_P. The result must equal the exact product for all operand pairs in both modes, including most-negative x most-negative (signed 4x4: -8*-8 = +64).
- o_product changes only at the DONE-entry edge or on reset. Intermediate accumulator values are never visible on the port.
- Input changes on operand ports outside the accepting edge have no effect.

Optional Feature:
Macro SEQ_MULTIPLIER_EARLY_TERMINATE_EN.
- Defined: at each RUN step, if all not-yet-processed multiplier bits (including the sign bit) are 0, the block goes to DONE at that edge and writes the final product. The same rule applies in both modes. Latency becomes 1..WIDTH_B steps. A multiplier of 0 finishes after 1 step.
- Undefined: latency is always exactly WIDTH_B steps. The zero-detect logic is not present.

Decomposition:
- Package seq_multiplier_pkg:
  - state encoding constants IDLE/RUN/DONE (2 bits)
  - counter-width function clog2(WIDTH_B+1)
- Sub-module mult_step: combinational accumulator update taking the accumulator, shifted multiplicand, bit, and add/sub select, returning the next accumulator. It is the natural split so the datapath can be unit-tested on its own.
- FSM, counter and registers stay in seq_multiplier.

Test Plan:
- Unsigned 15*15, WIDTH 4/4 -> o_product=225 (0xE1); o_finished pulses exactly 4 cycles after the start edge; o_busy high for 4 cycles.
- Signed -8*-8 -> 0x40; signed -1*7 -> 0xF9; signed 7*-8 -> 0xC8; the same bit patterns with i_signed=0 -> 0x40 becomes 8*8=0x40, 15*7=0x69, 7*8=0x38.
- Exhaustive sweep, both modes, WIDTH 4/4 and WIDTH_A=3/WIDTH_B=5 -> every product matches the reference model; the default build has no latency variation.
- i_start pulsed with new operands 2 cycles into RUN -> ignored; original product is delivered on schedule.
- i_reset asserted mid-RUN (cycle 2) -> next cycle o_busy=0, o_product=0, no o_finished pulse; a new start then completes normally.
- i_start held high through DONE -> second operation accepted with no idle cycle. With SEQ_MULTIPLIER_EARLY_TERMINATE_EN defined, 5*1 finishes after 1 step and 5*0 after 1 step, both with correct products.
